ram_bist: RTL

- Built-in self-test initiator that drives the single-port synchronous RAM's request port (rw/addr/datain) and consumes its dataout.
- Runs a two-pass write/read-back march over the whole array, compares every read word against the expected pattern, and reports pass/fail, the first failing address/data, and a saturating error count.
- Sits between the RAM instance and the test/control logic. The host only pulses start and waits for done.

---
 rtl/ram_bist.sv | 139 +++++++++++++
 1 files changed

// File: rtl/ram_bist.sv
// March-style built-in self-test for a single-port synchronous RAM: two write/read-back
// passes (pattern, then inverted pattern) with first-failure capture and a saturating error count.
module ram_bist #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_datain,
  input  logic [DATA_WIDTH-1:0] mem_dataout
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_TAIL, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                 state, state_nx;
  logic                   pass_idx;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [ADDR_WIDTH-1:0]  cmp_addr;
  logic                   cmp_valid;
  logic [DATA_WIDTH-1:0]  seed_q;
  logic [DATA_WIDTH-1:0]  cmp_exp;
  logic                   last;
  logic                   mismatch;
  logic                   err_full;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  inv,
    input logic [DATA_WIDTH-1:0] s
  );
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) ^ s;
    return inv ? ~p : p;
  endfunction

  assign last     = (addr == LAST_ADDR);
  assign cmp_exp  = pattern(cmp_addr, pass_idx, seed_q);
  assign mismatch = cmp_valid && (mem_dataout != cmp_exp);
  assign err_full = &err_count;

  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_WR;
      S_WR:           if (last)  state_nx = S_RD;
      S_RD:           if (last)  state_nx = S_TAIL;
      S_TAIL:         state_nx = pass_idx ? S_DONE : S_WR;
      default:        state_nx = S_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking assignment so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pass_idx   <= 1'b0;
      addr       <= '0;
      cmp_addr   <= '0;
      cmp_valid  <= 1'b0;
      seed_q     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
      err_count  <= '0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_datain <= '0;
    end else begin
      state     <= state_nx;
      cmp_valid <= 1'b0;
      mem_rw    <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            seed_q    <= seed;
            err_count <= '0;
            fail_addr <= '0;
            fail_data <= '0;
            pass      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            pass_idx  <= 1'b0;
            addr      <= '0;
          end
        end
        S_WR: begin
          mem_rw     <= 1'b1;
          mem_addr   <= addr;
          mem_datain <= pattern(addr, pass_idx, seed_q);
          addr       <= last ? '0 : addr + 1'b1;
        end
        S_RD: begin
          mem_addr  <= addr;
          cmp_valid <= 1'b1;
          cmp_addr  <= addr;
          addr      <= last ? '0 : addr + 1'b1;
        end
        S_TAIL: begin
          if (pass_idx) begin
            busy <= 1'b0;
            done <= 1'b1;
            // The final compare lands on this same edge, so fold it into the verdict.
            pass <= (err_count == '0) && !mismatch;
          end else begin
            pass_idx <= 1'b1;
          end
        end
        default: ;
      endcase

      if (mismatch) begin
        if (!err_full) err_count <= err_count + 1'b1;
        // err_count never returns to zero once set, so zero marks "no failure latched yet".
        if (err_count == '0) begin
          fail_addr <= cmp_addr;
          fail_data <= mem_dataout;
        end
      end
    end
  end

endmodule
